mod_exp_ctrl: RTL and testbench

Sequencing controller that computes o_result = i_base^i_exp mod i_mod by driving a single external shift-subtract modular multiplier through its load/ready handshake. It uses right-to-left binary square-and-multiply. Operands are registered, each multiplication is issued and awaited, and the accumulator and squared base are kept internally. It sits between the crypto command layer and the modular multiplier instance, and is the only master of that multiplier.

---
 rtl/mod_exp_ctrl_if.sv | 38 +++
 rtl/mod_exp_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_exp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_ctrl_if
// Brief    : Load/ready handshake bundle between mod_exp_ctrl and the
//            shift-subtract modular multiplier it sequences.
// Revision : 1.0 - initial release
// ============================================================================
interface mod_exp_ctrl_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  o_mul_load;
    logic [DATA_WIDTH-1:0] o_mul_a;
    logic [DATA_WIDTH-1:0] o_mul_b;
    logic [DATA_WIDTH-1:0] o_mul_m;
    logic                  i_mul_ready;
    logic [DATA_WIDTH-1:0] i_mul_p;

    // Controller side: issues operands, receives the product.
    modport master (
        output o_mul_load,
        output o_mul_a,
        output o_mul_b,
        output o_mul_m,
        input  i_mul_ready,
        input  i_mul_p
    );

    // Multiplier side.
    modport slave (
        input  o_mul_load,
        input  o_mul_a,
        input  o_mul_b,
        input  o_mul_m,
        output i_mul_ready,
        output i_mul_p
    );
endinterface
`default_nettype wire

// File: rtl/mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mod_exp_ctrl
// Brief    : Right-to-left square-and-multiply sequencer computing
//            base^exp mod m through one external modular multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module mod_exp_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int EXP_WIDTH  = 256
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    input  wire logic                  i_start,
    input  wire logic                  i_abort,
    input  wire logic [DATA_WIDTH-1:0] i_base,
    input  wire logic [EXP_WIDTH-1:0]  i_exp,
    input  wire logic [DATA_WIDTH-1:0] i_mod,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [DATA_WIDTH-1:0]      o_result,
    mod_exp_ctrl_if.master             mul
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_BIT   = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic                  c_OP_MUL = 1'b0;
    localparam logic                  c_OP_SQR = 1'b1;
    localparam logic [DATA_WIDTH-1:0] c_ONE    = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_THREE  = DATA_WIDTH'(3);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [DATA_WIDTH-1:0] r_mod;
    logic                  r_op_sel;
    logic                  r_err;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_base_nxt;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [EXP_WIDTH-1:0]  w_exp_nxt;
    logic [DATA_WIDTH-1:0] w_mod_nxt;
    logic                  w_op_sel_nxt;
    logic                  w_err_nxt;
    logic                  w_bad_operands;
    logic                  w_more_bits;

    assign w_bad_operands = ~r_mod[0] | (r_mod < c_THREE) | (r_base >= r_mod);
    assign w_more_bits    = |r_exp[EXP_WIDTH-1:1];

    always_comb begin
        w_state_nxt  = r_state;
        w_base_nxt   = r_base;
        w_acc_nxt    = r_acc;
        w_exp_nxt    = r_exp;
        w_mod_nxt    = r_mod;
        w_op_sel_nxt = r_op_sel;
        w_err_nxt    = r_err;

        // Abort outranks every other transition, including a ready in WAIT.
        if ((r_state != S_IDLE) && i_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_base_nxt  = i_base;
                        w_exp_nxt   = i_exp;
                        w_mod_nxt   = i_mod;
                        w_acc_nxt   = c_ONE;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad_operands) begin
                        w_acc_nxt   = '0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_BIT;
                    end
                end
                S_BIT: begin
                    if (r_exp == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_op_sel_nxt = r_exp[0] ? c_OP_MUL : c_OP_SQR;
                        w_state_nxt  = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (mul.i_mul_ready) begin
                        if (r_op_sel == c_OP_MUL) begin
                            w_acc_nxt = mul.i_mul_p;
                            // Square only while higher exponent bits remain; the
                            // exponent shift then happens after that square.
                            if (w_more_bits) begin
                                w_op_sel_nxt = c_OP_SQR;
                                w_state_nxt  = S_ISSUE;
                            end else begin
                                w_exp_nxt   = r_exp >> 1;
                                w_state_nxt = S_BIT;
                            end
                        end else begin
                            w_base_nxt  = mul.i_mul_p;
                            w_exp_nxt   = r_exp >> 1;
                            w_state_nxt = S_BIT;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_acc    <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_op_sel <= c_OP_MUL;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_base   <= w_base_nxt;
            r_acc    <= w_acc_nxt;
            r_exp    <= w_exp_nxt;
            r_mod    <= w_mod_nxt;
            r_op_sel <= w_op_sel_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Outputs are registered from the next-state decode so they line up with
    // the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_result       <= '0;
            mul.o_mul_load <= 1'b0;
            mul.o_mul_a    <= '0;
            mul.o_mul_b    <= '0;
            mul.o_mul_m    <= '0;
        end else begin
            o_busy         <= (w_state_nxt != S_IDLE);
            o_done         <= (w_state_nxt == S_DONE);
            o_err          <= (w_state_nxt == S_DONE) & w_err_nxt;
            mul.o_mul_load <= (w_state_nxt == S_ISSUE);
            if (w_state_nxt == S_DONE) begin
                o_result <= w_acc_nxt;
            end
            if (w_state_nxt == S_ISSUE) begin
                mul.o_mul_a <= (w_op_sel_nxt == c_OP_MUL) ? w_acc_nxt : w_base_nxt;
                mul.o_mul_b <= w_base_nxt;
                mul.o_mul_m <= w_mod_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_exp_ctrl
// Brief    : Self-checking bench for mod_exp_ctrl with a behavioural
//            multiplier and a plain-arithmetic exponentiation reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_exp_ctrl;
    localparam int DW = 16;
    localparam int EW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] base  = '0;
    logic [EW-1:0] expv  = '0;
    logic [DW-1:0] modv  = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] result;

    int n_vec = 0;
    int n_mis = 0;

    mod_exp_ctrl_if #(.DATA_WIDTH(DW)) mif ();

    mod_exp_ctrl #(.DATA_WIDTH(DW), .EXP_WIDTH(EW)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_abort  (abort),
        .i_base   (base),
        .i_exp    (expv),
        .i_mod    (modv),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .o_result (result),
        .mul      (mif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
        $fatal(1);
    end

    // Behavioural multiplier: product mod m after a random (or forced) latency.
    int            load_cnt   = 0;
    int            model_errs = 0;
    int            fixed_lat  = 0;
    int            epoch      = 0;
    int            pend_epoch = 0;
    int            lat_cnt    = 0;
    bit            pending    = 1'b0;
    logic [DW-1:0] pval       = '0;

    always @(negedge clk) begin
        mif.i_mul_ready = 1'b0;
        mif.i_mul_p     = DW'($urandom);
        if (mif.o_mul_load) begin
            load_cnt++;
            if (pending && (pend_epoch == epoch)) begin
                model_errs++;
                $display("FAIL load_overlap: got load while busy (load #%0d), required no overlap", load_cnt);
            end
            pending    = 1'b1;
            pend_epoch = epoch;
            if (mif.o_mul_m == '0)
                pval = '0;
            else
                pval = DW'((longint'(mif.o_mul_a) * longint'(mif.o_mul_b)) % longint'(mif.o_mul_m));
            if (fixed_lat > 0)
                lat_cnt = fixed_lat;
            else if ($urandom_range(0, 9) == 0)
                lat_cnt = $urandom_range(1, 40);
            else
                lat_cnt = $urandom_range(1, 3);
        end else if (pending) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                mif.i_mul_ready = 1'b1;
                mif.i_mul_p     = pval;
                pending         = 1'b0;
            end
        end
    end

    function automatic bit ref_err(longint b, longint m);
        return (m % 2 == 0) || (m < 3) || (b >= m);
    endfunction

    function automatic longint ref_pow(longint b, longint e, longint m);
        longint r = 1;
        for (longint i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    function automatic int ref_loads(longint e);
        int bl = 0;
        int pc = 0;
        for (int i = 0; i < 63; i++) begin
            if (e[i]) begin
                pc++;
                bl = i + 1;
            end
        end
        return (e == 0) ? 0 : pc + bl - 1;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_mis++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_op(input logic [DW-1:0] b, input logic [EW-1:0] e, input logic [DW-1:0] m,
                          input bit inject, output logic [DW-1:0] r, output logic er,
                          output int loads, output int dcyc, output logic busy1, output logic busy_after);
        int l0;
        int cyc;
        @(negedge clk);
        base  = b;
        expv  = e;
        modv  = m;
        start = 1'b1;
        l0    = load_cnt;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        busy1 = busy;
        while (!done && cyc < 20000) begin
            if (inject && cyc == 5) begin
                start = 1'b1;
                base  = ~b;
                expv  = e ^ 16'h0001;
                modv  = m ^ 16'h0002;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        r     = result;
        er    = err;
        loads = load_cnt - l0;
        dcyc  = done ? cyc : -1;
        @(negedge clk);
        busy_after = busy;
    endtask

    typedef struct {
        logic [DW-1:0] b;
        logic [EW-1:0] e;
        logic [DW-1:0] m;
        logic [DW-1:0] res;
        logic          er;
        int            loads;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [DW-1:0] r;
        logic          er;
        logic          b1;
        logic          ba;
        int            loads;
        int            dcyc;
        int            nl;
        int            seen_done;
        int            seen_busy;
        logic [DW-1:0] rb;
        logic [DW-1:0] rm;
        logic [EW-1:0] re;

        tbl[0] = '{16'd4,    16'd13,    16'd497,   16'd445,  1'b0, 6};
        tbl[1] = '{16'd3,    16'd65520, 16'd65521, 16'd1,    1'b0, 27};
        tbl[2] = '{16'd5,    16'd0,     16'd7,     16'd1,    1'b0, 0};
        tbl[3] = '{16'd9,    16'd5,     16'd7,     16'd0,    1'b1, 0};
        tbl[4] = '{16'd3,    16'd5,     16'd10,    16'd0,    1'b1, 0};
        tbl[5] = '{16'd2,    16'd3,     16'd3,     16'd2,    1'b0, 3};
        tbl[6] = '{16'd0,    16'd3,     16'd1,     16'd0,    1'b1, 0};
        tbl[7] = '{16'd2,    16'd10,    16'd1023,  16'd1,    1'b0, 5};
        tbl[8] = '{16'd1022, 16'd1,     16'd1023,  16'd1022, 1'b0, 1};
        tbl[9] = '{16'd7,    16'd7,     16'd7,     16'd0,    1'b1, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_err",    err, 0);
        chk("rst_result", result, 0);
        chk("rst_load",   mif.o_mul_load, 0);
        chk("rst_mul_a",  mif.o_mul_a, 0);
        chk("rst_mul_b",  mif.o_mul_b, 0);
        chk("rst_mul_m",  mif.o_mul_m, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].b, tbl[i].e, tbl[i].m, 1'b0, r, er, loads, dcyc, b1, ba);
            chk("tbl_timeout", (dcyc < 0), 0);
            chk("tbl_result", r, tbl[i].res);
            chk("tbl_err", er, tbl[i].er);
            chk("tbl_loads", loads, tbl[i].loads);
            chk("tbl_busy_c1", b1, 1);
            chk("tbl_busy_after", ba, 0);
            if (tbl[i].e == '0 && !tbl[i].er) chk("exp0_done_cycle", dcyc, 3);
        end

        for (int i = 0; i < 500; i++) begin
            rm = DW'($urandom_range(1, 32767) * 2 + 1);
            rb = DW'($urandom_range(0, int'(rm) - 1));
            re = ($urandom_range(0, 9) == 0) ? EW'($urandom) : EW'($urandom_range(0, 4095));
            run_op(rb, re, rm, (i % 4 == 0), r, er, loads, dcyc, b1, ba);
            chk("rnd_timeout", (dcyc < 0), 0);
            chk("rnd_result", r, ref_pow(rb, re, rm));
            chk("rnd_err", er, ref_err(rb, rm));
            chk("rnd_loads", loads, ref_loads(re));
        end

        // Abort during the third WAIT; previous result 4^13 mod 497 must survive.
        run_op(16'd4, 16'd13, 16'd497, 1'b0, r, er, loads, dcyc, b1, ba);
        chk("abort_pre_result", r, 445);
        fixed_lat = 12;
        @(negedge clk);
        base  = 16'd2;
        expv  = 16'h00ff;
        modv  = 16'd1001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nl    = 0;
        for (int c = 0; c < 2000 && nl < 3; c++) begin
            @(negedge clk);
            if (mif.o_mul_load) nl++;
        end
        chk("abort_third_load", nl, 3);
        @(negedge clk);
        abort = 1'b1;
        epoch++;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_load", mif.o_mul_load, 0);
        chk("abort_result", result, 445);
        seen_done = 0;
        seen_busy = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        chk("abort_stale_done", seen_done, 0);
        chk("abort_stale_busy", seen_busy, 0);
        chk("abort_hold_result", result, 445);
        fixed_lat = 0;
        run_op(16'd2, 16'd255, 16'd1001, 1'b0, r, er, loads, dcyc, b1, ba);
        chk("post_abort_result", r, ref_pow(2, 255, 1001));
        chk("post_abort_loads", loads, 15);

        // Asynchronous reset in the middle of a WAIT.
        fixed_lat = 15;
        @(negedge clk);
        base  = 16'd5;
        expv  = 16'd100;
        modv  = 16'd997;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nl    = 0;
        for (int c = 0; c < 200 && nl < 1; c++) begin
            @(negedge clk);
            if (mif.o_mul_load) nl++;
        end
        chk("rst_mid_load_seen", nl, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        epoch++;
        #1;
        chk("arst_busy",   busy, 0);
        chk("arst_done",   done, 0);
        chk("arst_err",    err, 0);
        chk("arst_result", result, 0);
        chk("arst_load",   mif.o_mul_load, 0);
        chk("arst_mul_a",  mif.o_mul_a, 0);
        chk("arst_mul_b",  mif.o_mul_b, 0);
        chk("arst_mul_m",  mif.o_mul_m, 0);
        repeat (20) @(negedge clk);
        rst_n     = 1'b1;
        fixed_lat = 0;
        run_op(16'd2, 16'd10, 16'd1023, 1'b0, r, er, loads, dcyc, b1, ba);
        chk("post_rst_result", r, 1);
        chk("post_rst_err", er, 0);
        chk("post_rst_loads", loads, 5);

        repeat (2) @(negedge clk);
        chk("model_overlap", model_errs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
